// File: rtl/clk_gen_pkg.sv
// Shared types and helpers for the multi-channel clock generator.
// Config fields are held at a fixed width so every channel width up to CFG_W fits.
package clk_gen_pkg;

    localparam int CNT_W_DEF = 8;
    localparam int CFG_W     = 16;

    typedef struct packed {
        logic             en;
        logic [CFG_W-1:0] period;
        logic [CFG_W-1:0] high;
    } ch_cfg_t;

    // A disable request is always acceptable; an enable needs a real high and low phase.
    function automatic logic cfg_is_valid(input ch_cfg_t c);
        if (!c.en) begin
            return 1'b1;
        end
        return (c.period >= CFG_W'(2)) && (c.high != '0) && (c.high < c.period);
    endfunction

endpackage

// File: rtl/clk_gen_ch.sv
// One output clock channel: counter, active/shadow config and boundary-aligned apply.
// Latency: a pending shadow goes live on the next idle edge or at the end of the current period.
module clk_gen_ch
    import clk_gen_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr,
    input  logic             wr_en,
    input  logic [CNT_W-1:0] wr_period,
    input  logic [CNT_W-1:0] wr_high,
    output logic             clk_out,
    output logic             tick,
    output logic             pending
);

    ch_cfg_t          act_q, act_d;
    ch_cfg_t          shd_q, shd_d;
    ch_cfg_t          wr_cfg;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pend_d, clk_d, tick_d;
    logic             at_end, apply;

    always_comb begin
        wr_cfg    = '0;
        wr_cfg.en = wr_en;
        if (wr_en) begin
            wr_cfg.period = CFG_W'(wr_period);
            wr_cfg.high   = CFG_W'(wr_high);
        end

        at_end = (CFG_W'(cnt_q) == (act_q.period - CFG_W'(1)));
        // Only swap configs while idle or on the last cycle of a period, so phases never get cut.
        apply  = pending && (!act_q.en || at_end);

        act_d  = apply ? shd_q : act_q;
        shd_d  = wr ? wr_cfg : shd_q;
        pend_d = wr || (pending && !apply);

        if (!act_d.en || apply || at_end) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        // Outputs are derived from the next count so clk_out is a clean register.
        clk_d  = act_d.en && (CFG_W'(cnt_d) < act_d.high);
        tick_d = act_d.en && (cnt_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_q   <= '0;
            shd_q   <= '0;
            pending <= 1'b0;
            cnt_q   <= '0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
        end else begin
            act_q   <= act_d;
            shd_q   <= shd_d;
            pending <= pend_d;
            cnt_q   <= cnt_d;
            clk_out <= clk_d;
            tick    <= tick_d;
        end
    end

endmodule

// File: rtl/clk_gen_multi.sv
// Multi-channel programmable clock generator: config handshake decode and validation.
// cfg_ready drops while the addressed channel holds an unapplied shadow; errors pulse one cycle later.
module clk_gen_multi
    import clk_gen_pkg::*;
#(
    parameter int  NUM_CH = 4,
    parameter int  CNT_W  = CNT_W_DEF,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic              cfg_en,
    input  logic [CNT_W-1:0]  cfg_period,
    input  logic [CNT_W-1:0]  cfg_high,
    output logic              cfg_err,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] pending
);

    localparam int PAD_N = 1 << CH_W;

    logic [PAD_N-1:0]  pend_pad;
    logic [NUM_CH-1:0] wr;
    logic              in_range, accept, cfg_ok;
    ch_cfg_t           req;

    // Padding bits read as "not pending", so out-of-range channels are always ready.
    assign pend_pad  = PAD_N'(pending);
    assign cfg_ready = !pend_pad[cfg_ch];
    assign accept    = cfg_valid && cfg_ready;

    always_comb begin
        in_range   = (int'(cfg_ch) < NUM_CH);
        req        = '0;
        req.en     = cfg_en;
        req.period = CFG_W'(cfg_period);
        req.high   = CFG_W'(cfg_high);
        cfg_ok     = in_range && cfg_is_valid(req);
        for (int i = 0; i < NUM_CH; i++) begin
            wr[i] = accept && cfg_ok && (int'(cfg_ch) == i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= accept && !cfg_ok;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        clk_gen_ch #(
            .CNT_W (CNT_W)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .wr        (wr[g]),
            .wr_en     (cfg_en),
            .wr_period (cfg_period),
            .wr_high   (cfg_high),
            .clk_out   (clk_out[g]),
            .tick      (tick[g]),
            .pending   (pending[g])
        );
    end

endmodule

// File: doc/clk_gen_multi.md
CLK_GEN_MULTI -- requirements
Module: clk_gen_multi

Interface
REQ-001 Parameter NUM_CH, default 4, number of independent output clock channels (1..16).
REQ-002 Parameter CNT_W, default 8, width of period/high-time counts in clk cycles.
REQ-003 clk  input  1  single system clock; all logic on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 cfg_valid  input  1  config request.
REQ-006 cfg_ready  output  1  config accept; handshake completes on a clk edge with cfg_valid&&cfg_ready.
REQ-007 cfg_ch  input  max(1,$clog2(NUM_CH))  target channel.
REQ-008 cfg_en  input  1  1 = run the channel, 0 = stop it.
REQ-009 cfg_period  input  CNT_W  output period in clk cycles.
REQ-010 cfg_high  input  CNT_W  high-phase length in clk cycles.
REQ-011 cfg_err  output  1  one-cycle pulse: the accepted request was rejected.
REQ-012 clk_out  output  NUM_CH  generated clocks, registered.
REQ-013 tick  output  NUM_CH  one-cycle pulse in the first cycle of each clk_out high phase.
REQ-014 pending  output  NUM_CH  the channel holds a shadow config not yet applied.

Function
REQ-015 Each channel has an active config {en, period, high}, a shadow config and a pending flag.
REQ-016 cfg_ready shall be !pending[cfg_ch]; an out-of-range cfg_ch shall give cfg_ready=1, and acceptance shall pulse cfg_err.
REQ-017 A request with cfg_en=1 and (period<2, or high==0, or high>=period) shall pulse cfg_err the cycle after acceptance and leave all channel state unchanged.
REQ-018 A request with cfg_en=0 shall always be valid; period and high are ignored.
REQ-019 A valid request shall write the shadow config and set pending on the acceptance edge.
REQ-020 Apply point: a pending shadow shall be copied to active and pending cleared at the first edge where the channel is disabled or the channel counter equals period-1, evaluated with the pending state before the acceptance edge, so it is never applied on the acceptance edge itself.
REQ-021 An enabled channel counter shall run 0..period-1 and wrap to 0; clk_out shall be 1 while cnt<high and 0 otherwise, giving exactly high cycles high and period-high cycles low.
REQ-022 Enabling an idle channel: the counter shall load 0 and clk_out shall rise on the edge after acceptance, i.e. 1-cycle latency, with tick=1 in that same cycle.
REQ-023 Reconfiguring or disabling a running channel shall take effect only at the period boundary, so no runt pulse or truncated phase appears on clk_out.
REQ-024 A disabled channel shall hold cnt=0, clk_out=0 and tick=0.
REQ-025 Channels shall be fully independent; one accept per cycle; cfg_err shall be shared across channels.

Reset
REQ-026 On rst_n low, asynchronously: all clk_out=0, tick=0, pending=0, cfg_err=0, counters 0, active and shadow en=0.
REQ-027 Reset mid-period shall stop every output immediately; after release, channels stay idle until configured.

Structure
REQ-028 Package clk_gen_pkg shall hold the CNT_W default, the channel config struct {en, period, high} and the validity-check function.
REQ-029 Sub-module clk_gen_ch shall implement one channel (counter, active/shadow registers, apply logic), instantiated NUM_CH times; the top level shall do handshake decode and validation only.

Verification
REQ-030 Enable ch0 with period=10, high=6 -> clk_out[0] rises 1 cycle after accept, then repeats 6 high / 4 low; tick[0] every 10 cycles.
REQ-031 Ch0 running 10/6, write period=4, high=1 mid-period -> pending[0]=1 and no change until cnt=9 edge; then 1 high / 3 low; no runt pulse.
REQ-032 Request period=5 with high=5, then high=0, then period=1 -> cfg_err pulses 3 times and the channel remains idle.
REQ-033 Ch1 running 8/4, second write issued while pending[1]=1 -> cfg_ready=0 until apply; a concurrent ch2 write is accepted immediately.
REQ-034 Ch3 running 6/3, disable -> current period completes, then clk_out[3]=0 and tick stays 0.
REQ-035 Assert rst_n low mid-high-phase on all channels -> clk_out all 0 at once; after release, outputs stay 0 until new config.
